imem_sync: RTL

//  Parametrised, synchronous-read instruction memory for the RV32 core's fetch stage.

---
 rtl/imem_sync.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_sync.sv
// rtl/imem_sync.sv - synchronous-read instruction memory with NOP fill, load port and fetch handshake
module imem_sync #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32,
    parameter logic [31:0] FILL  = 32'h00000013,
    parameter logic [31:0] BASE  = 32'h00000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] addr,
    output logic          ready,
    output logic          rvalid,
    input  logic          rready,
    output logic [31:0]   rdata,
    output logic          err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    output logic          busy
);

    localparam int unsigned   IW      = $clog2(DEPTH);
    localparam logic [AW-1:0] BASE_A  = AW'(BASE);
    localparam logic [AW-1:0] LIMIT_A = AW'(BASE) + AW'(4 * DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   fill_cnt;
    logic            mem_we;
    logic [IW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem [DEPTH];

    logic            fetch_acc;
    logic            fetch_err;
    logic [IW-1:0]   fetch_idx;
    logic            ld_in_range;
    logic [IW-1:0]   ld_idx;

    // Word index is taken relative to BASE; the range check guarantees the dropped high bits are zero.
    assign fetch_idx   = IW'((addr - BASE_A) >> 2);
    assign ld_idx      = IW'((ld_addr - BASE_A) >> 2);
    assign fetch_err   = (addr[1:0] != 2'b00) || (addr < BASE_A) || (addr >= LIMIT_A);
    assign ld_in_range = (ld_addr >= BASE_A) && (ld_addr < LIMIT_A);
    assign fetch_acc   = req && ready;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        ld_ready  = 1'b0;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = fill_cnt;
        mem_wdata = FILL;
        case (state)
            ST_INIT: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if (fill_cnt == IW'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                ld_ready = 1'b1;
                ready    = !rvalid || rready;
                if (ld_en && ld_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_idx;
                    mem_wdata = ld_data;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            fill_cnt <= '0;
            rvalid   <= 1'b0;
            rdata    <= 32'h0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= (state == ST_INIT) ? fill_cnt + 1'b1 : '0;
            // Response slot reads the array before this edge's write lands, giving read-first collisions.
            if (fetch_acc) begin
                rvalid <= 1'b1;
                err    <= fetch_err;
                rdata  <= fetch_err ? 32'h0 : mem[fetch_idx];
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
